// File: rtl/fifo_pkg.sv
// Shared helpers for the async FIFO pointer logic: binary/Gray conversion.
// Both functions work on a fixed 32-bit container. Callers zero-extend their
// pointer on the way in and cast the result back to the pointer width.
// Zero upper bits pass through both conversions unchanged, so truncating
// the result is exact.
package fifo_pkg;

    localparam int GRAY_W = 32;

    function automatic logic [GRAY_W-1:0] bin2gray(input logic [GRAY_W-1:0] b);
        return (b >> 1) ^ b;
    endfunction

    function automatic logic [GRAY_W-1:0] gray2bin(input logic [GRAY_W-1:0] g);
        logic [GRAY_W-1:0] b;
        b[GRAY_W-1] = g[GRAY_W-1];
        for (int i = GRAY_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_sync_r2w.sv
// Multi-flop synchronizer that carries the read-domain Gray pointer into wclk.
// The first flop samples the asynchronous input directly; there is no logic
// ahead of it.
module fifo_sync_r2w #(
    parameter int WIDTH  = 5,
    parameter int STAGES = 2
) (
    input  logic             wclk,
    input  logic             wrst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage [STAGES];

    // Shift chain: stage[0] takes the raw input, later stages settle metastability.
    always_ff @(posedge wclk) begin
        if (wrst) begin
            for (int i = 0; i < STAGES; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= din;
            for (int i = 1; i < STAGES; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign dout = stage[STAGES-1];

endmodule

// File: rtl/fifo_wptr_full.sv
// Write-side pointer and full-flag generator for the async FIFO (wclk domain).
// Produces the memory write address and the Gray write pointer exported to
// the read domain. Also produces the full, almost-full and sticky overflow
// flags, all derived from the synchronized read pointer.
module fifo_wptr_full
    import fifo_pkg::*;
#(
    parameter int ADDRSIZE     = 4,
    parameter int SYNC_STAGES  = 2,
    parameter int AFULL_MARGIN = 2
) (
    input  logic                wclk,
    input  logic                wrst,
    input  logic                winc,
    input  logic [ADDRSIZE:0]   rptr,
    input  logic                wovf_clr,
    output logic [ADDRSIZE-1:0] waddr,
    output logic [ADDRSIZE:0]   wptr,
    output logic                wfull,
    output logic                walmost_full,
    output logic                woverflow
);

    localparam int PTRW  = ADDRSIZE + 1;
    localparam int DEPTH = 1 << ADDRSIZE;
    localparam logic [ADDRSIZE:0] AFULL_LEVEL = PTRW'(DEPTH - AFULL_MARGIN);

    if (ADDRSIZE < 2) begin : g_bad_addrsize
        $error("fifo_wptr_full: ADDRSIZE must be at least 2");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("fifo_wptr_full: SYNC_STAGES must be at least 2");
    end
    if (AFULL_MARGIN < 1 || AFULL_MARGIN > DEPTH - 1) begin : g_bad_margin
        $error("fifo_wptr_full: AFULL_MARGIN must be in 1..DEPTH-1");
    end

    logic [ADDRSIZE:0] wbin;
    logic [ADDRSIZE:0] wbinnext;
    logic [ADDRSIZE:0] wgraynext;
    logic [ADDRSIZE:0] wq2_rptr;
    logic [ADDRSIZE:0] rbin;
    logic [ADDRSIZE:0] occ;
    logic              wfull_next;
    logic              wafull_next;
    logic              wovf_next;

    fifo_sync_r2w #(
        .WIDTH  (PTRW),
        .STAGES (SYNC_STAGES)
    ) u_sync_r2w (
        .wclk (wclk),
        .wrst (wrst),
        .din  (rptr),
        .dout (wq2_rptr)
    );

    // Next pointer values and flag conditions, evaluated against the
    // synchronized (therefore stale) read pointer. Stale means full clears
    // late, never early.
    always_comb begin
        wbinnext    = wbin + PTRW'(winc & ~wfull);
        wgraynext   = PTRW'(bin2gray(32'(wbinnext)));
        rbin        = PTRW'(gray2bin(32'(wq2_rptr)));
        // Modulo-2^PTRW difference; the extra wrap bit keeps 0 and DEPTH distinct.
        occ         = wbinnext - rbin;
        // Full in Gray terms: top two bits inverted, the rest equal.
        wfull_next  = (wgraynext == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]});
        wafull_next = (occ >= AFULL_LEVEL);
        // A fresh overflow beats a clear on the same edge.
        wovf_next   = (winc & wfull) | (woverflow & ~wovf_clr);
    end

    // Pointer and flag registers; reset dominates every other input.
    always_ff @(posedge wclk) begin
        if (wrst) begin
            wbin         <= '0;
            wptr         <= '0;
            wfull        <= 1'b0;
            walmost_full <= 1'b0;
            woverflow    <= 1'b0;
        end else begin
            wbin         <= wbinnext;
            wptr         <= wgraynext;
            wfull        <= wfull_next;
            walmost_full <= wafull_next;
            woverflow    <= wovf_next;
        end
    end

    assign waddr = wbin[ADDRSIZE-1:0];

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Bench for fifo_wptr_full. The driver updates an occupancy-count reference
// model on every edge and queues the expected outputs. A monitor pops one
// entry per edge and compares it against the DUT.
module tb_fifo_wptr_full;

    localparam int A     = 4;
    localparam int DEPTH = 16;
    localparam int SYNC  = 2;
    localparam int AFM   = 2;

    logic         wclk = 1'b0;
    logic         wrst;
    logic         winc;
    logic [A:0]   rptr;
    logic         wovf_clr;
    logic [A-1:0] waddr;
    logic [A:0]   wptr;
    logic         wfull;
    logic         walmost_full;
    logic         woverflow;

    fifo_wptr_full #(.ADDRSIZE(A), .SYNC_STAGES(SYNC), .AFULL_MARGIN(AFM)) dut (
        .wclk         (wclk),
        .wrst         (wrst),
        .winc         (winc),
        .rptr         (rptr),
        .wovf_clr     (wovf_clr),
        .waddr        (waddr),
        .wptr         (wptr),
        .wfull        (wfull),
        .walmost_full (walmost_full),
        .woverflow    (woverflow)
    );

    always #5 wclk = ~wclk;

    typedef struct {
        int addr;
        int ptr;
        bit full;
        bit afull;
        bit ovf;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    bit   driver_done = 0;

    // Reference model state: total accepted writes and total reads, as plain
    // integers. The read pointer reaches the write side SYNC edges late.
    int   m_wr   = 0;
    int   rd     = 0;
    bit   m_full = 0;
    bit   m_af   = 0;
    bit   m_ovf  = 0;
    int   hist[$];

    function automatic int gray(input int b);
        int v;
        v = b % 32;
        return v ^ (v / 2);
    endfunction

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // One wclk edge: drive inputs, let the model step at the edge, queue the result.
    task automatic cyc(input bit r, input bit inc, input bit clr);
        int   seen;
        int   occ;
        exp_t e;
        wrst     = r;
        winc     = inc;
        wovf_clr = clr;
        rptr     = (A+1)'(gray(rd));
        @(posedge wclk);
        if (r) begin
            m_wr   = 0;
            m_full = 0;
            m_af   = 0;
            m_ovf  = 0;
            hist   = {0, 0};
        end else begin
            seen   = hist[0];
            m_ovf  = (inc && m_full) || (m_ovf && !clr);
            if (inc && !m_full) m_wr++;
            occ    = m_wr - seen;
            m_full = (occ == DEPTH);
            m_af   = (occ >= DEPTH - AFM);
            void'(hist.pop_front());
            hist.push_back(rd);
        end
        e.addr  = m_wr % DEPTH;
        e.ptr   = gray(m_wr);
        e.full  = m_full;
        e.afull = m_af;
        e.ovf   = m_ovf;
        exp_q.push_back(e);
        @(negedge wclk);
    endtask

    // Monitor: after every edge, compare DUT outputs against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge wclk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("sb_waddr", int'(waddr), e.addr);
                check("sb_wptr", int'(wptr), e.ptr);
                check("sb_wfull", int'(wfull), int'(e.full));
                check("sb_walmost_full", int'(walmost_full), int'(e.afull));
                check("sb_woverflow", int'(woverflow), int'(e.ovf));
            end
        end
    end

    // Driver: directed scenarios followed by a randomized run.
    initial begin
        hist = {0, 0};
        wrst = 1'b1; winc = 1'b0; wovf_clr = 1'b0; rptr = '0;

        // Reset with winc held high.
        rd = 0;
        repeat (3) cyc(1, 1, 0);
        check("rst_waddr", int'(waddr), 0);
        check("rst_wptr", int'(wptr), 0);
        check("rst_wfull", int'(wfull), 0);
        check("rst_afull", int'(walmost_full), 0);
        check("rst_ovf", int'(woverflow), 0);

        // Fill with rptr parked at 0.
        for (int i = 1; i <= 16; i++) begin
            cyc(0, 1, 0);
            if (i == 13) check("fill13_afull", int'(walmost_full), 0);
            if (i == 14) check("fill14_afull", int'(walmost_full), 1);
            if (i == 15) check("fill15_full", int'(wfull), 0);
        end
        check("fill_full", int'(wfull), 1);
        check("fill_wptr", int'(wptr), 24);
        check("fill_waddr", int'(waddr), 0);

        // Overflow, clear, then a new overflow on the same edge as a clear.
        cyc(0, 1, 0);
        check("ovf_wptr_hold", int'(wptr), 24);
        check("ovf_set", int'(woverflow), 1);
        cyc(0, 0, 1);
        check("ovf_clr", int'(woverflow), 0);
        cyc(0, 1, 0);
        check("ovf_reset", int'(woverflow), 1);
        cyc(0, 1, 1);
        check("ovf_set_wins", int'(woverflow), 1);
        cyc(0, 0, 1);
        check("ovf_clr2", int'(woverflow), 0);

        // One read: full clears exactly three edges after rptr moves.
        rd = 1;
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        check("drain_full_e2", int'(wfull), 1);
        cyc(0, 0, 0);
        check("drain_full_e3", int'(wfull), 0);
        check("drain_afull", int'(walmost_full), 1);

        // Wrap: 32 writes with the reader close behind.
        rd = 0;
        cyc(1, 0, 0);
        for (int i = 1; i <= 32; i++) begin
            cyc(0, 1, 0);
            check("wrap_nofull", int'(wfull), 0);
            if (i == 31) begin
                check("wrap31_wptr", int'(wptr), 16);
                check("wrap31_waddr", int'(waddr), 15);
            end
            rd = m_wr;
        end
        check("wrap32_wptr", int'(wptr), 0);
        check("wrap32_waddr", int'(waddr), 0);

        // Reset in the middle of a fill, then refill completely.
        rd = 0;
        cyc(1, 0, 0);
        repeat (7) cyc(0, 1, 0);
        cyc(1, 1, 0);
        check("mid_rst_wptr", int'(wptr), 0);
        check("mid_rst_waddr", int'(waddr), 0);
        check("mid_rst_afull", int'(walmost_full), 0);
        for (int i = 1; i <= 16; i++) begin
            cyc(0, 1, 0);
            if (i == 15) check("refill15_full", int'(wfull), 0);
        end
        check("refill16_full", int'(wfull), 1);

        // Random traffic: reads lag writes, occasional clears and resets.
        for (int i = 0; i < 600; i++) begin
            bit r;
            r = ($urandom_range(0, 149) == 0);
            if (r) begin
                rd = 0;
            end else if (rd < m_wr && $urandom_range(0, 2) != 0) begin
                rd++;
            end
            cyc(r, ($urandom_range(0, 3) != 0), ($urandom_range(0, 11) == 0));
        end

        cyc(0, 0, 0);
        @(posedge wclk);
        #2;
        check("sb_drained", exp_q.size(), 0);
        driver_done = 1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
